// File: rtl/ddc_demux_pkg.sv
// Shared encodings for the DDC receive-side de-multiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the link has none, every qualified word is consumed.
package ddc_demux_pkg;

    // Parallel-mode lane FSM: waiting for an I word, or holding one for its Q.
    typedef enum logic {
        L_IDLE  = 1'b0,
        L_GOT_I = 1'b1
    } lane_state_e;

    // Serial-mode frame FSM: the state number is the channel index expected next.
    typedef enum logic [1:0] {
        S_WAIT0 = 2'd0,
        S_EXP1  = 2'd1,
        S_EXP2  = 2'd2,
        S_EXP3  = 2'd3
    } ser_state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam int ERRCNT_W = 16;

endpackage

// File: rtl/ddc_demux_lane.sv
// Parallel-mode lane: pairs an I word with the following Q word, flags order violations.
// Latency: combinational pair/err strobes in the cycle the Q word arrives; the top registers them.
// Backpressure: none; a word is consumed every cycle its flag is high.
module ddc_demux_lane
    import ddc_demux_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic [W-1:0] dat_i,
    input  logic         dat_vld_i,
    input  logic         iq_i,
    output logic [W-1:0] i_o,
    output logic [W-1:0] q_o,
    output logic         vld_o,
    output logic         err_o
);

    lane_state_e  state_q, state_d;
    logic [W-1:0] i_q, i_d;

    // Q completes a pair straight from the input word; I comes from the latch.
    assign i_o = i_q;
    assign q_o = dat_i;

    // Next-state, I latch and strobes; a flush (link mode change) forces idle silently.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        vld_o   = 1'b0;
        err_o   = 1'b0;
        if (flush_i) begin
            state_d = L_IDLE;
        end else if (en_i) begin
            case (state_q)
                L_IDLE: begin
                    if (dat_vld_i) begin
                        if (iq_i) begin
                            i_d     = dat_i;
                            state_d = L_GOT_I;
                        end else begin
                            err_o = 1'b1;
                        end
                    end
                end
                L_GOT_I: begin
                    if (dat_vld_i) begin
                        if (!iq_i) begin
                            vld_o   = 1'b1;
                            state_d = L_IDLE;
                        end else begin
                            // A second I replaces the first; the pair will use the newer one.
                            err_o = 1'b1;
                            i_d   = dat_i;
                        end
                    end else begin
                        err_o   = 1'b1;
                        state_d = L_IDLE;
                    end
                end
                default: state_d = L_IDLE;
            endcase
        end
    end

    // State and latched I word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= L_IDLE;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
        end
    end

endmodule

// File: rtl/ddc_datain_demux.sv
// DDC output de-multiplexer: rebuilds per-channel I/Q pairs (parallel or serial link), flags framing errors.
// Latency: parallel pair visible 1 cycle after its Q word; serial frame visible 1 cycle after its idx-3 word.
// Backpressure: none; optional saturating error counter when DDC_DEMUX_ERRCNT_EN is defined.
module ddc_datain_demux
    import ddc_demux_pkg::*;
#(
    parameter int ADBITWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  para_ser_sel,
    input  logic [ADBITWIDTH-1:0] ca_iq_data,
    input  logic [ADBITWIDTH-1:0] cb_iq_data,
    input  logic [ADBITWIDTH-1:0] cc_iq_data,
    input  logic [ADBITWIDTH-1:0] cd_iq_data,
    input  logic                  data_flaga,
    input  logic                  data_flagb,
    input  logic                  data_flagc,
    input  logic                  data_flagd,
    input  logic                  iq_flaga,
    input  logic                  iq_flagb,
    input  logic                  iq_flagc,
    input  logic                  iq_flagd,
    output logic [ADBITWIDTH-1:0] ch_a_i,
    output logic [ADBITWIDTH-1:0] ch_a_q,
    output logic [ADBITWIDTH-1:0] ch_b_i,
    output logic [ADBITWIDTH-1:0] ch_b_q,
    output logic [ADBITWIDTH-1:0] ch_c_i,
    output logic [ADBITWIDTH-1:0] ch_c_q,
    output logic [ADBITWIDTH-1:0] ch_d_i,
    output logic [ADBITWIDTH-1:0] ch_d_q,
    output logic [3:0]            ch_valid,
    output logic [3:0]            seq_err
`ifdef DDC_DEMUX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]   err_cnt
`endif
);

    localparam int W = ADBITWIDTH;

    // Link mode tracking; a mode change cycle flushes every FSM and emits nothing.
    logic mode_q;
    logic mode_sw;
    logic lane_en;

    assign mode_sw = para_ser_sel ^ mode_q;
    assign lane_en = para_ser_sel & ~mode_sw;

    // Parallel lanes.
    logic [W-1:0] lane_dat [4];
    logic [W-1:0] lane_i   [4];
    logic [W-1:0] lane_qw  [4];
    logic [3:0]   lane_dflag;
    logic [3:0]   lane_iq;
    logic [3:0]   lane_vld;
    logic [3:0]   lane_err;

    assign lane_dat[0] = ca_iq_data;
    assign lane_dat[1] = cb_iq_data;
    assign lane_dat[2] = cc_iq_data;
    assign lane_dat[3] = cd_iq_data;
    assign lane_dflag  = {data_flagd, data_flagc, data_flagb, data_flaga};
    assign lane_iq     = {iq_flagd, iq_flagc, iq_flagb, iq_flaga};

    for (genvar k = 0; k < 4; k++) begin : g_lane
        ddc_demux_lane #(.W(W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en_i      (lane_en),
            .flush_i   (mode_sw),
            .dat_i     (lane_dat[k]),
            .dat_vld_i (lane_dflag[k]),
            .iq_i      (lane_iq[k]),
            .i_o       (lane_i[k]),
            .q_o       (lane_qw[k]),
            .vld_o     (lane_vld[k]),
            .err_o     (lane_err[k])
        );
    end

    // Serial framing: channels 0..2 wait in shadows, channel 3 goes straight to the outputs.
    ser_state_e   ser_state_q, ser_state_d;
    logic [W-1:0] shd_i_q [3];
    logic [W-1:0] shd_i_d [3];
    logic [W-1:0] shd_q_q [3];
    logic [W-1:0] shd_q_d [3];
    logic         ser_word;
    logic         ser_half;
    logic [1:0]   ser_idx;
    logic         ser_vld;
    logic         ser_err;

    assign ser_word = data_flaga & data_flagb;
    assign ser_half = data_flaga ^ data_flagb;
    assign ser_idx  = {iq_flaga, iq_flagb};

    // Output registers.
    logic [W-1:0] ch_i_q [4];
    logic [W-1:0] ch_i_d [4];
    logic [W-1:0] ch_q_q [4];
    logic [W-1:0] ch_q_d [4];
    logic [3:0]   ch_valid_q, ch_valid_d;
    logic [3:0]   seq_err_q, seq_err_d;

    // Serial frame FSM: track the expected index, fill shadows, resync on index 0.
    always_comb begin
        ser_state_d = ser_state_q;
        shd_i_d     = shd_i_q;
        shd_q_d     = shd_q_q;
        ser_vld     = 1'b0;
        ser_err     = 1'b0;
        if (mode_sw) begin
            ser_state_d = S_WAIT0;
        end else if (!para_ser_sel) begin
            if (ser_half) begin
                ser_err     = 1'b1;
                ser_state_d = S_WAIT0;
            end else if (ser_word) begin
                if (ser_state_e'(ser_idx) == ser_state_q) begin
                    case (ser_state_q)
                        S_WAIT0: begin
                            shd_i_d[CH_A] = ca_iq_data;
                            shd_q_d[CH_A] = cb_iq_data;
                            ser_state_d   = S_EXP1;
                        end
                        S_EXP1: begin
                            shd_i_d[CH_B] = ca_iq_data;
                            shd_q_d[CH_B] = cb_iq_data;
                            ser_state_d   = S_EXP2;
                        end
                        S_EXP2: begin
                            shd_i_d[CH_C] = ca_iq_data;
                            shd_q_d[CH_C] = cb_iq_data;
                            ser_state_d   = S_EXP3;
                        end
                        default: begin
                            ser_vld     = 1'b1;
                            ser_state_d = S_WAIT0;
                        end
                    endcase
                end else begin
                    ser_err = 1'b1;
                    // An index-0 word mid-frame starts a new frame rather than being lost.
                    if (ser_idx == CH_A) begin
                        shd_i_d[CH_A] = ca_iq_data;
                        shd_q_d[CH_A] = cb_iq_data;
                        ser_state_d   = S_EXP1;
                    end else begin
                        ser_state_d = S_WAIT0;
                    end
                end
            end else if (ser_state_q != S_WAIT0) begin
                ser_err     = 1'b1;
                ser_state_d = S_WAIT0;
            end
        end
    end

    // Output next-values: lane pairs in parallel mode, whole frames in serial mode.
    always_comb begin
        ch_i_d     = ch_i_q;
        ch_q_d     = ch_q_q;
        ch_valid_d = '0;
        seq_err_d  = '0;
        if (!mode_sw) begin
            if (para_ser_sel) begin
                for (int k = 0; k < 4; k++) begin
                    if (lane_vld[k]) begin
                        ch_i_d[k] = lane_i[k];
                        ch_q_d[k] = lane_qw[k];
                    end
                end
                ch_valid_d = lane_vld;
                seq_err_d  = lane_err;
            end else begin
                if (ser_vld) begin
                    ch_i_d[CH_A] = shd_i_q[CH_A];
                    ch_q_d[CH_A] = shd_q_q[CH_A];
                    ch_i_d[CH_B] = shd_i_q[CH_B];
                    ch_q_d[CH_B] = shd_q_q[CH_B];
                    ch_i_d[CH_C] = shd_i_q[CH_C];
                    ch_q_d[CH_C] = shd_q_q[CH_C];
                    ch_i_d[CH_D] = ca_iq_data;
                    ch_q_d[CH_D] = cb_iq_data;
                    ch_valid_d   = 4'b1111;
                end
                seq_err_d[0] = ser_err;
            end
        end
    end

    // Mode, serial FSM, shadows and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= 1'b1;
            ser_state_q <= S_WAIT0;
            shd_i_q     <= '{default: '0};
            shd_q_q     <= '{default: '0};
            ch_i_q      <= '{default: '0};
            ch_q_q      <= '{default: '0};
            ch_valid_q  <= '0;
            seq_err_q   <= '0;
        end else begin
            mode_q      <= para_ser_sel;
            ser_state_q <= ser_state_d;
            shd_i_q     <= shd_i_d;
            shd_q_q     <= shd_q_d;
            ch_i_q      <= ch_i_d;
            ch_q_q      <= ch_q_d;
            ch_valid_q  <= ch_valid_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign ch_a_i   = ch_i_q[CH_A];
    assign ch_a_q   = ch_q_q[CH_A];
    assign ch_b_i   = ch_i_q[CH_B];
    assign ch_b_q   = ch_q_q[CH_B];
    assign ch_c_i   = ch_i_q[CH_C];
    assign ch_c_q   = ch_q_q[CH_C];
    assign ch_d_i   = ch_i_q[CH_D];
    assign ch_d_q   = ch_q_q[CH_D];
    assign ch_valid = ch_valid_q;
    assign seq_err  = seq_err_q;

`ifdef DDC_DEMUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q;

    // Saturating count of cycles that raise any seq_err bit, moving with the seq_err output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if ((|seq_err_d) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ddc_datain_demux.sv
module tb_ddc_datain_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [15:0] dat [4];
    logic [3:0]  dflag;
    logic [3:0]  iqf;

    logic [15:0] ch_a_i, ch_a_q, ch_b_i, ch_b_q, ch_c_i, ch_c_q, ch_d_i, ch_d_q;
    logic [3:0]  ch_valid, seq_err;
`ifdef DDC_DEMUX_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    logic [15:0] dut_i [4];
    logic [15:0] dut_q [4];
    assign dut_i[0] = ch_a_i;
    assign dut_i[1] = ch_b_i;
    assign dut_i[2] = ch_c_i;
    assign dut_i[3] = ch_d_i;
    assign dut_q[0] = ch_a_q;
    assign dut_q[1] = ch_b_q;
    assign dut_q[2] = ch_c_q;
    assign dut_q[3] = ch_d_q;

    ddc_datain_demux #(.ADBITWIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .para_ser_sel (sel),
        .ca_iq_data   (dat[0]),
        .cb_iq_data   (dat[1]),
        .cc_iq_data   (dat[2]),
        .cd_iq_data   (dat[3]),
        .data_flaga   (dflag[0]),
        .data_flagb   (dflag[1]),
        .data_flagc   (dflag[2]),
        .data_flagd   (dflag[3]),
        .iq_flaga     (iqf[0]),
        .iq_flagb     (iqf[1]),
        .iq_flagc     (iqf[2]),
        .iq_flagd     (iqf[3]),
        .ch_a_i       (ch_a_i),
        .ch_a_q       (ch_a_q),
        .ch_b_i       (ch_b_i),
        .ch_b_q       (ch_b_q),
        .ch_c_i       (ch_c_i),
        .ch_c_q       (ch_c_q),
        .ch_d_i       (ch_d_i),
        .ch_d_q       (ch_d_q),
        .ch_valid     (ch_valid),
        .seq_err      (seq_err)
`ifdef DDC_DEMUX_ERRCNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state: expected registered outputs and pending work.
    logic [15:0] exp_i [4];
    logic [15:0] exp_q [4];
    logic [3:0]  exp_vld, exp_err;
    logic [15:0] exp_cnt;
    logic        mode_m;
    bit          pend_v [4];
    logic [15:0] pend_d [4];
    logic [15:0] fq_i [$];
    logic [15:0] fq_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_i[k]  = '0;
            exp_q[k]  = '0;
            pend_v[k] = 1'b0;
            pend_d[k] = '0;
        end
        exp_vld = '0;
        exp_err = '0;
        exp_cnt = '0;
        mode_m  = 1'b1;
        fq_i.delete();
        fq_q.delete();
    endtask

    // One clock edge worth of the specified behaviour, using the inputs as driven.
    task automatic model_update();
        logic [1:0] idx;
        exp_vld = '0;
        exp_err = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (sel != mode_m) begin
            for (int k = 0; k < 4; k++) pend_v[k] = 1'b0;
            fq_i.delete();
            fq_q.delete();
        end else if (sel) begin
            for (int k = 0; k < 4; k++) begin
                if (dflag[k]) begin
                    if (iqf[k]) begin
                        if (pend_v[k]) exp_err[k] = 1'b1;
                        pend_v[k] = 1'b1;
                        pend_d[k] = dat[k];
                    end else if (pend_v[k]) begin
                        exp_i[k]   = pend_d[k];
                        exp_q[k]   = dat[k];
                        exp_vld[k] = 1'b1;
                        pend_v[k]  = 1'b0;
                    end else begin
                        exp_err[k] = 1'b1;
                    end
                end else if (pend_v[k]) begin
                    exp_err[k] = 1'b1;
                    pend_v[k]  = 1'b0;
                end
            end
        end else begin
            idx = {iqf[0], iqf[1]};
            if (dflag[0] ^ dflag[1]) begin
                exp_err[0] = 1'b1;
                fq_i.delete();
                fq_q.delete();
            end else if (dflag[0] & dflag[1]) begin
                if (int'(idx) == fq_i.size()) begin
                    fq_i.push_back(dat[0]);
                    fq_q.push_back(dat[1]);
                    if (fq_i.size() == 4) begin
                        for (int j = 0; j < 4; j++) begin
                            exp_i[j] = fq_i[j];
                            exp_q[j] = fq_q[j];
                        end
                        exp_vld = 4'hF;
                        fq_i.delete();
                        fq_q.delete();
                    end
                end else begin
                    exp_err[0] = 1'b1;
                    fq_i.delete();
                    fq_q.delete();
                    if (idx == 2'd0) begin
                        fq_i.push_back(dat[0]);
                        fq_q.push_back(dat[1]);
                    end
                end
            end else if (fq_i.size() != 0) begin
                exp_err[0] = 1'b1;
                fq_i.delete();
                fq_q.delete();
            end
        end
        if (exp_err != 0 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        mode_m = sel;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        dflag = '0;
        iqf   = '0;
    endtask

    task automatic par(input int k, input logic is_i, input logic [15:0] d);
        dflag[k] = 1'b1;
        iqf[k]   = is_i;
        dat[k]   = d;
    endtask

    task automatic ser(input logic [1:0] idx, input logic [15:0] vi, input logic [15:0] vq);
        dflag  = 4'b0011;
        iqf    = {2'b00, idx[0], idx[1]};
        dat[0] = vi;
        dat[1] = vq;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("ch_i[%0d]", k), 64'(dut_i[k]), 64'(exp_i[k]));
                chk($sformatf("ch_q[%0d]", k), 64'(dut_q[k]), 64'(exp_q[k]));
            end
            chk("ch_valid", 64'(ch_valid), 64'(exp_vld));
            chk("seq_err", 64'(seq_err), 64'(exp_err));
`ifdef DDC_DEMUX_ERRCNT_EN
            chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Staggered parallel pattern: 0 idle, 1 I word, 2 Q word; lane c runs back-to-back.
    logic [1:0] tbl [7][4];
    logic [15:0] held;

    initial begin
        tbl = '{'{2'd1, 2'd0, 2'd0, 2'd0},
                '{2'd2, 2'd1, 2'd1, 2'd0},
                '{2'd0, 2'd2, 2'd2, 2'd1},
                '{2'd0, 2'd0, 2'd1, 2'd2},
                '{2'd0, 2'd0, 2'd2, 2'd0},
                '{2'd0, 2'd0, 2'd1, 2'd0},
                '{2'd0, 2'd0, 2'd2, 2'd0}};
        rst_n = 1'b0;
        sel   = 1'b1;
        for (int k = 0; k < 4; k++) dat[k] = '0;
        idle();
        model_reset();
        step();
        chk_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reset_ch_a_i", 64'(ch_a_i), 64'h0);
        chk("reset_ch_valid", 64'(ch_valid), 64'h0);
        chk("reset_seq_err", 64'(seq_err), 64'h0);

        // Single pair on lane a.
        par(0, 1'b1, 16'h1234);
        step();
        idle();
        par(0, 1'b0, 16'hABCD);
        step();
        idle();
        chk("lane_a_i", 64'(ch_a_i), 64'h1234);
        chk("lane_a_q", 64'(ch_a_q), 64'hABCD);
        chk("lane_a_valid", 64'(ch_valid), 64'h1);
        step();
        chk("lane_a_valid_pulse", 64'(ch_valid), 64'h0);

        // All lanes staggered.
        for (int c = 0; c < 7; c++) begin
            idle();
            for (int k = 0; k < 4; k++) begin
                if (tbl[c][k] != 2'd0) par(k, tbl[c][k] == 2'd1, 16'hA000 + 16'(k * 16'h1000) + 16'(c));
            end
            step();
        end
        idle();
        chk("lane_c_b2b_q", 64'(ch_c_q), 64'hC006);
        chk("lane_c_b2b_i", 64'(ch_c_i), 64'hC005);
        step();

        // Lane b ordering violations.
        par(1, 1'b0, 16'h0BAD);
        step();
        idle();
        chk("b_q_without_i", 64'(seq_err), 64'h2);
        par(1, 1'b1, 16'h1111);
        step();
        par(1, 1'b1, 16'h2222);
        step();
        chk("b_double_i", 64'(seq_err), 64'h2);
        par(1, 1'b0, 16'h3333);
        step();
        idle();
        chk("b_pair_second_i", 64'(ch_b_i), 64'h2222);
        chk("b_pair_valid", 64'(ch_valid), 64'h2);
        par(1, 1'b1, 16'h4444);
        step();
        idle();
        step();
        chk("b_i_then_idle_err", 64'(seq_err), 64'h2);
        chk("b_i_then_idle_vld", 64'(ch_valid), 64'h0);

        // Serial mode: one switch cycle, then a clean frame.
        sel = 1'b0;
        step();
        for (int n = 0; n < 4; n++) begin
            ser(2'(n), 16'h0100 + 16'(n), 16'h0200 + 16'(n));
            step();
        end
        idle();
        chk("ser_frame_valid", 64'(ch_valid), 64'hF);
        chk("ser_frame_a_i", 64'(ch_a_i), 64'h0100);
        chk("ser_frame_d_q", 64'(ch_d_q), 64'h0203);
        step();

        // Serial resync: 0,1,0,1,2,3.
        ser(2'd0, 16'h7000, 16'h8000);
        step();
        ser(2'd1, 16'h7001, 16'h8001);
        step();
        ser(2'd0, 16'h7002, 16'h8002);
        step();
        chk("ser_resync_err", 64'(seq_err), 64'h1);
        for (int n = 1; n < 4; n++) begin
            ser(2'(n), 16'h7010 + 16'(n), 16'h8010 + 16'(n));
            step();
        end
        idle();
        chk("ser_resync_valid", 64'(ch_valid), 64'hF);
        chk("ser_resync_a_i", 64'(ch_a_i), 64'h7002);
        step();

        // Mode toggle while lane a holds an I.
        sel = 1'b1;
        step();
        held = ch_a_i;
        par(0, 1'b1, 16'h5555);
        step();
        sel = 1'b0;
        par(0, 1'b0, 16'h6666);
        step();
        idle();
        chk("toggle_no_valid", 64'(ch_valid), 64'h0);
        chk("toggle_no_err", 64'(seq_err), 64'h0);
        chk("toggle_hold_a_i", 64'(ch_a_i), 64'(held));

        // Reset in the middle of a serial frame.
        ser(2'd0, 16'h9000, 16'h9100);
        step();
        ser(2'd1, 16'h9001, 16'h9101);
        step();
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_a_i", 64'(ch_a_i), 64'h0);
        chk("midreset_valid", 64'(ch_valid), 64'h0);
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic in both modes.
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] idx;
            int r;
            if ($urandom_range(0, 63) == 0) sel = ~sel;
            idle();
            for (int k = 0; k < 4; k++) dat[k] = 16'($urandom);
            if (sel) begin
                for (int k = 0; k < 4; k++) begin
                    dflag[k] = ($urandom_range(0, 3) != 0);
                    iqf[k]   = pend_v[k] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
                end
            end else begin
                dflag[3:2] = 2'($urandom);
                iqf[3:2]   = 2'($urandom);
                r = $urandom_range(0, 15);
                if (r == 0) begin
                    dflag[1:0] = 2'b01;
                end else if (r == 1) begin
                    dflag[1:0] = 2'b10;
                end else if (r >= 4) begin
                    dflag[1:0] = 2'b11;
                    idx = ($urandom_range(0, 7) != 0) ? 2'(fq_i.size()) : 2'($urandom_range(0, 3));
                    iqf[0] = idx[1];
                    iqf[1] = idx[0];
                end
            end
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
